// File: rtl/window3x3_gen_pkg.sv
// -----------------------------------------------------------------------------
// window3x3_gen_pkg
// Shared definitions for the 3x3 sliding-window front end and the conv/pooling
// stages that consume its output.
//   state_t    : frame-tracking FSM encoding (IDLE, ACTIVE)
//   WIN_TAPS   : number of pixels in one window
//   win_slice  : maps (row, column) of the window to its slice index in the
//                packed window bus; r=0 is the oldest row, c=0 the oldest column
// -----------------------------------------------------------------------------
package window3x3_gen_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam int WIN_TAPS = 9;

   // Slice index of tap (r, c); the tap occupies [DATA_WIDTH*idx +: DATA_WIDTH].
   function automatic int win_slice(input int r, input int c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/window_line_delay.sv
// -----------------------------------------------------------------------------
// window_line_delay
// Delays a pixel stream by exactly DEPTH enabled cycles using a circular RAM.
// The output is valid combinationally at the enabled edge, so it lines up with
// the pixel currently being accepted (no extra read latency for the caller).
//   clock  : rising-edge clock
//   rst_n  : asynchronous active-low reset (pointer only)
//   clken  : advance the delay by one pixel
//   din    : pixel entering the delay
//   dout   : pixel that entered DEPTH enabled cycles before the current one
// -----------------------------------------------------------------------------
module window_line_delay #(
   parameter int DEPTH      = 416,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  clken,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   // The registered RAM output supplies one stage of the delay, so the array
   // itself only needs DEPTH-1 slots.
   localparam int RAM_DEPTH = DEPTH - 1;
   localparam int AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [AW-1:0]         ptr_q;
   logic [DATA_WIDTH-1:0] rd_q;

   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values of its neighbours, independent of block ordering.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (clken) begin
         if (ptr_q == AW'(RAM_DEPTH - 1)) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= ptr_q + 1'b1;
         end
      end
   end

   // NOTE: the RAM and its read register carry no reset; stale contents are
   // hidden by the row gating in the window generator, and a reset here would
   // stop the array mapping onto block/distributed RAM.
   // Read-before-write: the slot being overwritten is returned to the caller.
   always_ff @(posedge clock) begin
      if (clken) begin
         rd_q         <= mem[ptr_q];
         mem[ptr_q]   <= din;
      end
   end

   assign dout = rd_q;

endmodule

// File: rtl/window3x3_gen.sv
// -----------------------------------------------------------------------------
// window3x3_gen
// Sliding 3x3 window generator for raster-order pixel streams. Two cascaded
// line delays provide the two previous rows; per-row column history provides
// the two previous columns. One window is emitted per accepted pixel once the
// window lies entirely inside the frame (no padding).
//   clock     : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : pixel qualifier, one pixel per cycle when high
//   in_sof    : first pixel of a frame (sampled with in_valid)
//   in_data   : pixel value
//   out_valid : window qualifier (latency 1 from the accepting edge)
//   out_win   : window, tap (r,c) at [DATA_WIDTH*(3r+c) +: DATA_WIDTH]
//   out_eof   : high with the last window of a frame
//   sof_err   : one-cycle pulse when in_sof arrives mid-frame
// -----------------------------------------------------------------------------
module window3x3_gen
   import window3x3_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = 416,
   parameter int IMG_HEIGHT = 416,
   parameter int DATA_WIDTH = 8
) (
   input  logic                           clock,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic                           in_sof,
   input  logic [DATA_WIDTH-1:0]          in_data,
   output logic                           out_valid,
   output logic [WIN_TAPS*DATA_WIDTH-1:0] out_win,
   output logic                           out_eof,
   output logic                           sof_err
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);

   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   state_t                state_q, state_d;
   logic [XW-1:0]         x_q, x_d, x_cur;
   logic [YW-1:0]         y_q, y_d, y_cur;
   logic                  accept;
   logic                  last_pix;
   logic                  win_ok;

   logic [DATA_WIDTH-1:0] row1_px;
   logic [DATA_WIDTH-1:0] row0_px;

   // Two older columns per row; the newest column is the incoming pixel set.
   logic [DATA_WIDTH-1:0] hist_q [3][2];
   logic [DATA_WIDTH-1:0] win_d  [3][3];

   // In IDLE only a start-of-frame pixel is accepted; stray pixels are dropped.
   assign accept = in_valid & (in_sof | (state_q == ST_ACTIVE));

   // A start-of-frame pixel is always (0,0), even when it interrupts a frame.
   assign x_cur    = in_sof ? '0 : x_q;
   assign y_cur    = in_sof ? '0 : y_q;
   assign last_pix = (x_cur == X_LAST) && (y_cur == Y_LAST);
   assign win_ok   = accept && (x_cur >= XW'(2)) && (y_cur >= YW'(2));

   // ---------------------------------------------------------------------------
   // Frame-position FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // NOTE: every output of this block is given a default before any branch,
   // so no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      if (accept) begin
         state_d = ST_ACTIVE;
         if (x_cur == X_LAST) begin
            x_d = '0;
            if (y_cur == Y_LAST) begin
               y_d     = '0;
               state_d = ST_IDLE;
            end else begin
               y_d = y_cur + 1'b1;
            end
         end else begin
            x_d = x_cur + 1'b1;
            y_d = y_cur;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Line delays: row1 is the previous line, row0 the one before it
   // ---------------------------------------------------------------------------
   window_line_delay #(
      .DEPTH      (IMG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_delay_row1 (
      .clock (clock),
      .rst_n (rst_n),
      .clken (accept),
      .din   (in_data),
      .dout  (row1_px)
   );

   window_line_delay #(
      .DEPTH      (IMG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_delay_row0 (
      .clock (clock),
      .rst_n (rst_n),
      .clken (accept),
      .din   (row1_px),
      .dout  (row0_px)
   );

   // ---------------------------------------------------------------------------
   // Column shift: window as it stands after this pixel's shift
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_d[r][0] = hist_q[r][0];
         win_d[r][1] = hist_q[r][1];
      end
      win_d[0][2] = row0_px;
      win_d[1][2] = row1_px;
      win_d[2][2] = in_data;
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            hist_q[r][0] <= hist_q[r][1];
            hist_q[r][1] <= win_d[r][2];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         sof_err   <= 1'b0;
         out_win   <= '0;
      end else begin
         out_valid <= win_ok;
         out_eof   <= win_ok & last_pix;
         sof_err   <= in_valid & in_sof & (state_q == ST_ACTIVE);
         // The window bus holds its last value between valid windows.
         if (win_ok) begin
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 3; c++) begin
                  out_win[DATA_WIDTH*win_slice(r, c) +: DATA_WIDTH] <= win_d[r][c];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_window3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_window3x3_gen
// Directed bench for window3x3_gen with a 5x4 frame, pixel = 16*y + x.
// -----------------------------------------------------------------------------
module tb_window3x3_gen;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int DW = 8;
   localparam int BW = 9 * DW;

   localparam logic [BW-1:0] FIRST_WIN = 72'h222120121110020100;
   localparam logic [BW-1:0] LAST_WIN  = 72'h343332242322141312;

   logic          clock = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_sof;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic [BW-1:0] out_win;
   logic          out_eof;
   logic          sof_err;

   int total = 0;
   int bad   = 0;

   int            nwin, neof, nwin2, neof2;
   logic [BW-1:0] fw, lw, fw2, lw2;

   window3x3_gen #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .DATA_WIDTH (DW)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_win   (out_win),
      .out_eof   (out_eof),
      .sof_err   (sof_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected window whose newest pixel is (x, y).
   function automatic logic [BW-1:0] win_at(input int x, input int y);
      logic [BW-1:0] w;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w[DW*(3*r+c) +: DW] = DW'(16 * (y - 2 + r) + (x - 2 + c));
         end
      end
      return w;
   endfunction

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      @(posedge clock);
      #1;
      check("gap_valid", out_valid, 1'b0);
      check("gap_eof", out_eof, 1'b0);
   endtask

   // Sends the first n pixels of a frame (raster order, in_sof on pixel 0).
   task automatic run_pixels(input int n, input bit gaps, input bit err_first,
                             output int nw, output int ne,
                             output logic [BW-1:0] first_w, output logic [BW-1:0] last_w);
      int x;
      int y;
      bit ev;
      nw      = 0;
      ne      = 0;
      first_w = '0;
      last_w  = '0;
      for (int i = 0; i < n; i++) begin
         x = i % W;
         y = i / W;
         if (gaps && ($urandom_range(0, 1) == 1)) idle_cycle();
         in_valid = 1'b1;
         in_sof   = (i == 0);
         in_data  = DW'(16 * y + x);
         @(posedge clock);
         #1;
         ev = (x >= 2) && (y >= 2);
         check("win_valid", out_valid, ev);
         check("sof_err", sof_err, (i == 0) && err_first);
         check("eof", out_eof, ev && (x == W - 1) && (y == H - 1));
         if (out_valid === 1'b1) begin
            nw++;
            if (nw == 1) first_w = out_win;
            last_w = out_win;
            check("win_data", out_win, win_at(x, y));
         end
         if (out_eof === 1'b1) ne++;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
      #12;
      check("rst_valid", out_valid, 1'b0);
      check("rst_eof", out_eof, 1'b0);
      check("rst_sof_err", sof_err, 1'b0);
      check("rst_win", out_win, '0);
      @(negedge clock);
      rst_n = 1'b1;
      idle_cycle();

      // Continuous frame
      run_pixels(20, 1'b0, 1'b0, nwin, neof, fw, lw);
      check("t1_count", nwin, 6);
      check("t1_eofs", neof, 1);
      check("t1_first", fw, FIRST_WIN);
      check("t1_last", lw, LAST_WIN);
      idle_cycle();
      check("hold_win", out_win, LAST_WIN);

      // Same frame with random gaps
      run_pixels(20, 1'b1, 1'b0, nwin, neof, fw, lw);
      check("t2_count", nwin, 6);
      check("t2_eofs", neof, 1);
      check("t2_first", fw, FIRST_WIN);
      check("t2_last", lw, LAST_WIN);
      idle_cycle();

      // Pixels without in_sof after reset are ignored
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_sof   = 1'b0;
         in_data  = 8'hAA;
         @(posedge clock);
         #1;
         check("stray_valid", out_valid, 1'b0);
      end
      run_pixels(20, 1'b0, 1'b0, nwin, neof, fw, lw);
      check("t3_count", nwin, 6);
      check("t3_first", fw, FIRST_WIN);
      check("t3_last", lw, LAST_WIN);
      idle_cycle();

      // in_sof at pixel (3,2) of frame A
      run_pixels(13, 1'b0, 1'b0, nwin, neof, fw, lw);
      check("t4a_count", nwin, 1);
      run_pixels(20, 1'b0, 1'b1, nwin, neof, fw, lw);
      check("t4_count", nwin, 6);
      check("t4_eofs", neof, 1);
      check("t4_first", fw, FIRST_WIN);
      check("t4_last", lw, LAST_WIN);
      idle_cycle();

      // Two frames back-to-back
      run_pixels(20, 1'b0, 1'b0, nwin, neof, fw, lw);
      run_pixels(20, 1'b0, 1'b0, nwin2, neof2, fw2, lw2);
      check("t5_count", nwin + nwin2, 12);
      check("t5_eofs", neof + neof2, 2);
      check("t5_first2", fw2, FIRST_WIN);
      check("t5_last2", lw2, LAST_WIN);
      idle_cycle();

      // Asynchronous reset at pixel (3,3)
      run_pixels(18, 1'b0, 1'b0, nwin, neof, fw, lw);
      in_valid = 1'b1;
      in_sof   = 1'b0;
      in_data  = 8'h33;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_eof", out_eof, 1'b0);
      check("arst_sof_err", sof_err, 1'b0);
      check("arst_win", out_win, '0);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      check("arst_hold", out_valid, 1'b0);
      rst_n = 1'b1;
      idle_cycle();
      run_pixels(20, 1'b0, 1'b0, nwin, neof, fw, lw);
      check("t6_count", nwin, 6);
      check("t6_eofs", neof, 1);
      check("t6_first", fw, FIRST_WIN);
      check("t6_last", lw, LAST_WIN);
      idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
